// File: rtl/handshake_ff_pack.sv
// Byte-to-word packer on a valid/ready stream: COUNT bytes (or fewer when
// i_last arrives) become one registered word with a contiguous keep mask.
module handshake_ff_pack #(
    parameter  int COUNT = 4,
    localparam int LW    = $clog2(COUNT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         i_value,
    input  logic               i_last,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [8*COUNT-1:0] o_value,
    output logic [COUNT-1:0]   o_keep,
    output logic               o_last,
    output logic               o_valid,
    input  logic               i_ready
);

    logic [8*COUNT-1:0] acc;
    logic [LW-1:0]      cnt;
    logic [8*COUNT-1:0] word_d;
    logic [COUNT-1:0]   keep_d;
    logic               acc_en;
    logic               at_end;
    logic               close;

    assign o_ready = ~reset & (~o_valid | i_ready);
    assign acc_en  = i_valid & o_ready;
    assign at_end  = (cnt == LW'(COUNT - 1));
    assign close   = acc_en & (at_end | i_last);

    // Lanes above cnt are always zero in acc, so merging the incoming
    // byte into lane[cnt] yields the zero-padded word directly.
    always_comb begin
        word_d = acc;
        keep_d = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (LW'(k) == cnt) begin
                word_d[8*k +: 8] = i_value;
            end
            if (LW'(k) <= cnt) begin
                keep_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            o_value <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
        end else if (close) begin
            o_value <= word_d;
            o_keep  <= keep_d;
            o_last  <= i_last;
            o_valid <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            if (acc_en) begin
                acc <= word_d;
                cnt <= cnt + LW'(1);
            end
            if (o_valid & i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
